uart_tx_feeder: RTL and testbench

UART_TX_FEEDER -- requirements
Module: uart_tx_feeder

---
 rtl/uart_tx_feeder_if.sv | 29 ++
 rtl/uart_tx_feeder.sv | 112 +++++++++++
 tb/tb_uart_tx_feeder.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_feeder_if.sv
// Producer and transmitter-side signals of the UART TX feeder, bundled for port use.
// slave is the feeder's view; master is the producer/transmitter environment view.
`timescale 1ns/1ps
interface uart_tx_feeder_if #(
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          wr_en;
  logic [7:0]    wr_data;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          overflow;
  logic          clr_ovf;
  logic          tx_buffer_empty;
  logic [7:0]    din;
  logic          wrn;

  modport slave (
    input  wr_en, wr_data, clr_ovf, tx_buffer_empty,
    output full, empty, count, overflow, din, wrn
  );

  modport master (
    output wr_en, wr_data, clr_ovf, tx_buffer_empty,
    input  full, empty, count, overflow, din, wrn
  );
endinterface

// File: rtl/uart_tx_feeder.sv
// Byte FIFO feeding a parallel-load UART transmitter: LOAD sets up DIN, STROBE pulses WRN low,
// HOLD waits for the transmitter's buffer-empty flag to drop (or a guard timeout) before the next byte.
`timescale 1ns/1ps
module uart_tx_feeder #(
  parameter int DEPTH     = 16,
  parameter int WRN_WIDTH = 2,
  parameter int GUARD     = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  uart_tx_feeder_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, LOAD, STROBE, HOLD} state_t;

  state_t        state_q, state_d;
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          ovf_q, ovf_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [7:0]    din_q, din_d;
  logic          wrn_q, wrn_d;
  logic          push_ok, push_drop, pop;

  // A pop only ever happens in LOAD, which is entered only when the FIFO is non-empty.
  assign push_ok   = bus.wr_en && !full_q;
  assign push_drop = bus.wr_en && full_q;
  assign pop       = (state_q == LOAD);

  always_comb begin
    wptr_d  = push_ok ? wptr_q + AW'(1) : wptr_q;
    rptr_d  = pop ? rptr_q + AW'(1) : rptr_q;
    count_d = count_q + CW'(push_ok) - CW'(pop);
    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == '0);
    if (push_drop)
      ovf_d = 1'b1;
    else if (bus.clr_ovf)
      ovf_d = 1'b0;
    else
      ovf_d = ovf_q;
  end

  always_ff @(posedge clk_i) begin
    if (push_ok)
      mem_q[wptr_q] <= bus.wr_data;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
      din_q   <= 8'h00;
      wrn_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
      din_q   <= din_d;
      wrn_q   <= wrn_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (!empty_q && bus.tx_buffer_empty) state_d = LOAD;
      LOAD:    state_d = STROBE;
      STROBE:  if (cnt_q == '0) state_d = HOLD;
      HOLD:    if (!bus.tx_buffer_empty || cnt_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // DIN is captured on the edge entering LOAD so it has a full cycle of setup before WRN falls.
  always_comb begin
    cnt_d = cnt_q;
    din_d = din_q;
    unique case (state_q)
      IDLE:    if (state_d == LOAD) din_d = mem_q[rptr_q];
      LOAD:    cnt_d = 4'(WRN_WIDTH - 1);
      STROBE:  cnt_d = (cnt_q == '0) ? 4'(GUARD - 1) : cnt_q - 4'd1;
      HOLD:    if (cnt_q != '0) cnt_d = cnt_q - 4'd1;
      default: cnt_d = '0;
    endcase
    wrn_d = (state_d != STROBE);
  end

  assign bus.full     = full_q;
  assign bus.empty    = empty_q;
  assign bus.count    = count_q;
  assign bus.overflow = ovf_q;
  assign bus.din      = din_q;
  assign bus.wrn      = wrn_q;
endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder with a small transmitter model capturing DIN on each WRN fall.
`timescale 1ns/1ps
module tb_uart_tx_feeder;
  localparam int DEPTH     = 16;
  localparam int WRN_WIDTH = 2;
  localparam int GUARD     = 4;
  localparam int SPACING   = 1 + WRN_WIDTH + GUARD + 1;

  logic clk = 1'b0;
  logic rst;
  int   vec = 0;
  int   err = 0;

  // Transmitter model state: mode 0 holds TX_BUFFER_EMPTY low, 1 holds it high,
  // 2 drops it 2 cycles after each WRN fall for 3 cycles.
  int         mode = 0;
  int         cyc = 0;
  int         drop_dly = 0;
  int         low_cnt = 0;
  logic       prev_wrn = 1'b1;
  logic [7:0] rx_q[$];
  int         fall_q[$];

  uart_tx_feeder_if #(.DEPTH(DEPTH)) bus();

  uart_tx_feeder #(.DEPTH(DEPTH), .WRN_WIDTH(WRN_WIDTH), .GUARD(GUARD)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    if (prev_wrn && !bus.wrn) begin
      rx_q.push_back(bus.din);
      fall_q.push_back(cyc);
      drop_dly = 2;
    end
    prev_wrn = bus.wrn;
    if (drop_dly > 0) begin
      drop_dly = drop_dly - 1;
      if (drop_dly == 0) low_cnt = 3;
    end
    if (mode == 0)
      bus.tx_buffer_empty = 1'b0;
    else if (mode == 1)
      bus.tx_buffer_empty = 1'b1;
    else if (low_cnt > 0) begin
      bus.tx_buffer_empty = 1'b0;
      low_cnt = low_cnt - 1;
    end else
      bus.tx_buffer_empty = 1'b1;
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vec++; if (bus.wrn !== 1'b1) begin err++; $display("FAIL reset_wrn: got %b want 1", bus.wrn); end
    vec++; if (bus.din !== 8'h00) begin err++; $display("FAIL reset_din: got %h want 00", bus.din); end
    vec++; if (bus.empty !== 1'b1) begin err++; $display("FAIL reset_empty: got %b want 1", bus.empty); end
    vec++; if (bus.full !== 1'b0) begin err++; $display("FAIL reset_full: got %b want 0", bus.full); end
    vec++; if (bus.count !== 5'd0) begin err++; $display("FAIL reset_count: got %0d want 0", bus.count); end
    vec++; if (bus.overflow !== 1'b0) begin err++; $display("FAIL reset_ovf: got %b want 0", bus.overflow); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_byte();
    int base;
    mode = 1;
    repeat (3) @(negedge clk);
    base = rx_q.size();
    bus.wr_en = 1'b1; bus.wr_data = 8'hA5;
    @(negedge clk);
    bus.wr_en = 1'b0;
    vec++; if (bus.empty !== 1'b0) begin err++; $display("FAIL single_empty_fall: got %b want 0", bus.empty); end
    vec++; if (bus.count !== 5'd1) begin err++; $display("FAIL single_count: got %0d want 1", bus.count); end
    @(negedge clk);
    vec++; if (bus.din !== 8'hA5) begin err++; $display("FAIL single_din_load: got %h want a5", bus.din); end
    vec++; if (bus.wrn !== 1'b1) begin err++; $display("FAIL single_wrn_load: got %b want 1", bus.wrn); end
    @(negedge clk);
    vec++; if (bus.wrn !== 1'b0) begin err++; $display("FAIL single_wrn_low1: got %b want 0", bus.wrn); end
    vec++; if (bus.empty !== 1'b1) begin err++; $display("FAIL single_empty_pop: got %b want 1", bus.empty); end
    @(negedge clk);
    vec++; if (bus.wrn !== 1'b0) begin err++; $display("FAIL single_wrn_low2: got %b want 0", bus.wrn); end
    @(negedge clk);
    vec++; if (bus.wrn !== 1'b1) begin err++; $display("FAIL single_wrn_rise: got %b want 1", bus.wrn); end
    vec++; if (rx_q.size() !== base + 1) begin err++; $display("FAIL single_rx_count: got %0d want %0d", rx_q.size(), base + 1); end
    else begin
      vec++; if (rx_q[base] !== 8'hA5) begin err++; $display("FAIL single_rx_byte: got %h want a5", rx_q[base]); end
    end
    repeat (12) @(negedge clk);
  endtask

  task automatic test_backpressure();
    int base;
    int t;
    logic [7:0] exp_b [3];
    exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33;
    mode = 0;
    repeat (3) @(negedge clk);
    base = rx_q.size();
    for (int i = 0; i < 3; i++) begin
      bus.wr_en = 1'b1; bus.wr_data = exp_b[i];
      @(negedge clk);
    end
    bus.wr_en = 1'b0;
    repeat (5) @(negedge clk);
    vec++; if (bus.wrn !== 1'b1) begin err++; $display("FAIL bp_wrn_idle: got %b want 1", bus.wrn); end
    vec++; if (bus.count !== 5'd3) begin err++; $display("FAIL bp_count: got %0d want 3", bus.count); end
    vec++; if (rx_q.size() !== base) begin err++; $display("FAIL bp_no_strobe: got %0d want %0d", rx_q.size(), base); end
    mode = 2;
    t = 0;
    while (rx_q.size() < base + 3 && t < 300) begin @(negedge clk); t++; end
    vec++; if (rx_q.size() !== base + 3) begin err++; $display("FAIL bp_rx_count: got %0d want %0d", rx_q.size(), base + 3); end
    else begin
      for (int i = 0; i < 3; i++) begin
        vec++; if (rx_q[base+i] !== exp_b[i]) begin err++; $display("FAIL bp_rx_byte%0d: got %h want %h", i, rx_q[base+i], exp_b[i]); end
      end
    end
    repeat (15) @(negedge clk);
    vec++; if (bus.empty !== 1'b1) begin err++; $display("FAIL bp_drained: got %b want 1", bus.empty); end
  endtask

  task automatic test_overflow();
    int base;
    int t;
    mode = 0;
    repeat (3) @(negedge clk);
    base = rx_q.size();
    for (int i = 0; i < 17; i++) begin
      bus.wr_en = 1'b1; bus.wr_data = 8'h40 + 8'(i);
      @(negedge clk);
    end
    bus.wr_en = 1'b0;
    vec++; if (bus.full !== 1'b1) begin err++; $display("FAIL ovf_full: got %b want 1", bus.full); end
    vec++; if (bus.count !== 5'd16) begin err++; $display("FAIL ovf_count: got %0d want 16", bus.count); end
    vec++; if (bus.overflow !== 1'b1) begin err++; $display("FAIL ovf_flag: got %b want 1", bus.overflow); end
    bus.wr_en = 1'b1; bus.wr_data = 8'h51; bus.clr_ovf = 1'b1;
    @(negedge clk);
    bus.wr_en = 1'b0; bus.clr_ovf = 1'b0;
    vec++; if (bus.overflow !== 1'b1) begin err++; $display("FAIL ovf_set_priority: got %b want 1", bus.overflow); end
    vec++; if (bus.count !== 5'd16) begin err++; $display("FAIL ovf_count_hold: got %0d want 16", bus.count); end
    bus.clr_ovf = 1'b1;
    @(negedge clk);
    bus.clr_ovf = 1'b0;
    vec++; if (bus.overflow !== 1'b0) begin err++; $display("FAIL ovf_clear: got %b want 0", bus.overflow); end
    mode = 1;
    t = 0;
    while (rx_q.size() < base + 16 && t < 400) begin @(negedge clk); t++; end
    repeat (30) @(negedge clk);
    vec++; if (rx_q.size() !== base + 16) begin err++; $display("FAIL ovf_rx_count: got %0d want %0d", rx_q.size(), base + 16); end
    else begin
      for (int i = 0; i < 16; i++) begin
        vec++; if (rx_q[base+i] !== 8'h40 + 8'(i)) begin err++; $display("FAIL ovf_rx_byte%0d: got %h want %h", i, rx_q[base+i], 8'h40 + 8'(i)); end
      end
    end
  endtask

  task automatic test_push_pop_full();
    int base;
    int t;
    mode = 0;
    repeat (3) @(negedge clk);
    base = rx_q.size();
    for (int i = 0; i < 16; i++) begin
      bus.wr_en = 1'b1; bus.wr_data = 8'h60 + 8'(i);
      @(negedge clk);
    end
    bus.wr_en = 1'b0;
    vec++; if (bus.full !== 1'b1) begin err++; $display("FAIL ppf_full: got %b want 1", bus.full); end
    mode = 1;
    @(negedge clk);
    @(negedge clk);
    vec++; if (bus.din !== 8'h60) begin err++; $display("FAIL ppf_din_load: got %h want 60", bus.din); end
    bus.wr_en = 1'b1; bus.wr_data = 8'hEE;
    @(negedge clk);
    bus.wr_en = 1'b0;
    vec++; if (bus.count !== 5'd15) begin err++; $display("FAIL ppf_count: got %0d want 15", bus.count); end
    vec++; if (bus.overflow !== 1'b1) begin err++; $display("FAIL ppf_ovf: got %b want 1", bus.overflow); end
    vec++; if (bus.full !== 1'b0) begin err++; $display("FAIL ppf_not_full: got %b want 0", bus.full); end
    bus.clr_ovf = 1'b1;
    @(negedge clk);
    bus.clr_ovf = 1'b0;
    t = 0;
    while (rx_q.size() < base + 16 && t < 400) begin @(negedge clk); t++; end
    repeat (30) @(negedge clk);
    vec++; if (rx_q.size() !== base + 16) begin err++; $display("FAIL ppf_rx_count: got %0d want %0d", rx_q.size(), base + 16); end
    else begin
      for (int i = 0; i < 16; i++) begin
        vec++; if (rx_q[base+i] !== 8'h60 + 8'(i)) begin err++; $display("FAIL ppf_rx_byte%0d: got %h want %h", i, rx_q[base+i], 8'h60 + 8'(i)); end
      end
    end
  endtask

  task automatic test_wrap();
    int base;
    int t;
    mode = 2;
    repeat (3) @(negedge clk);
    base = rx_q.size();
    for (int i = 0; i < 40; i++) begin
      t = 0;
      while (bus.full === 1'b1 && t < 200) begin @(negedge clk); t++; end
      bus.wr_en = 1'b1; bus.wr_data = 8'(i);
      @(negedge clk);
      bus.wr_en = 1'b0;
    end
    t = 0;
    while (rx_q.size() < base + 40 && t < 2000) begin @(negedge clk); t++; end
    vec++; if (rx_q.size() !== base + 40) begin err++; $display("FAIL wrap_rx_count: got %0d want %0d", rx_q.size(), base + 40); end
    else begin
      for (int i = 0; i < 40; i++) begin
        vec++; if (rx_q[base+i] !== 8'(i)) begin err++; $display("FAIL wrap_rx_byte%0d: got %h want %h", i, rx_q[base+i], 8'(i)); end
      end
    end
    vec++; if (bus.overflow !== 1'b0) begin err++; $display("FAIL wrap_no_ovf: got %b want 0", bus.overflow); end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_guard_spacing();
    int fb;
    int t;
    mode = 1;
    repeat (20) @(negedge clk);
    fb = fall_q.size();
    for (int i = 0; i < 3; i++) begin
      bus.wr_en = 1'b1; bus.wr_data = 8'h80 + 8'(i);
      @(negedge clk);
    end
    bus.wr_en = 1'b0;
    t = 0;
    while (fall_q.size() < fb + 3 && t < 200) begin @(negedge clk); t++; end
    vec++; if (fall_q.size() !== fb + 3) begin err++; $display("FAIL guard_strobes: got %0d want %0d", fall_q.size(), fb + 3); end
    else begin
      vec++; if (fall_q[fb+1] - fall_q[fb] !== SPACING) begin err++; $display("FAIL guard_gap1: got %0d want %0d", fall_q[fb+1] - fall_q[fb], SPACING); end
      vec++; if (fall_q[fb+2] - fall_q[fb+1] !== SPACING) begin err++; $display("FAIL guard_gap2: got %0d want %0d", fall_q[fb+2] - fall_q[fb+1], SPACING); end
    end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_reset_midstrobe();
    int base;
    int t;
    mode = 1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      bus.wr_en = 1'b1; bus.wr_data = 8'h70 + 8'(i);
      @(negedge clk);
    end
    bus.wr_en = 1'b0;
    t = 0;
    while (bus.wrn !== 1'b0 && t < 50) begin @(negedge clk); t++; end
    vec++; if (bus.wrn !== 1'b0) begin err++; $display("FAIL rst_mid_reach_strobe: got %b want 0", bus.wrn); end
    rst = 1'b1;
    #1;
    vec++; if (bus.wrn !== 1'b1) begin err++; $display("FAIL rst_mid_wrn: got %b want 1", bus.wrn); end
    vec++; if (bus.count !== 5'd0) begin err++; $display("FAIL rst_mid_count: got %0d want 0", bus.count); end
    vec++; if (bus.empty !== 1'b1) begin err++; $display("FAIL rst_mid_empty: got %b want 1", bus.empty); end
    vec++; if (bus.din !== 8'h00) begin err++; $display("FAIL rst_mid_din: got %h want 00", bus.din); end
    @(negedge clk);
    base = rx_q.size();
    rst = 1'b0;
    bus.wr_en = 1'b1; bus.wr_data = 8'h99;
    @(negedge clk);
    bus.wr_en = 1'b0;
    vec++; if (bus.count !== 5'd1) begin err++; $display("FAIL rst_first_push: got %0d want 1", bus.count); end
    t = 0;
    while (rx_q.size() < base + 1 && t < 50) begin @(negedge clk); t++; end
    repeat (40) @(negedge clk);
    vec++; if (rx_q.size() !== base + 1) begin err++; $display("FAIL rst_rx_count: got %0d want %0d", rx_q.size(), base + 1); end
    else begin
      vec++; if (rx_q[base] !== 8'h99) begin err++; $display("FAIL rst_rx_byte: got %h want 99", rx_q[base]); end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.wr_en = 1'b0;
    bus.wr_data = 8'h00;
    bus.clr_ovf = 1'b0;
    bus.tx_buffer_empty = 1'b0;
    test_reset();
    test_single_byte();
    test_backpressure();
    test_overflow();
    test_push_pop_full();
    test_wrap();
    test_guard_spacing();
    test_reset_midstrobe();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
